// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped console UART: window base, register
// offsets, LSR bit positions and the RX poll state encoding.
package uart_mmio_pkg;

  localparam logic [63:0] UART_BASE   = 64'h0000_0000_1000_0000;
  localparam logic [2:0]  UART_THR    = 3'd0;
  localparam logic [2:0]  UART_LSR    = 3'd5;
  localparam int          LSR_DR      = 0;
  localparam int          LSR_THRE    = 5;
  localparam int          LSR_TEMT    = 6;
  localparam logic [7:0]  UART_NODATA = 8'hFF;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_POLL = 2'd1,
    S_HOLD = 2'd2
  } rx_state_e;

  // Places a byte into its lane of a 64-bit data word.
  function automatic logic [63:0] lane_place(input logic [2:0] lane, input logic [7:0] b);
    return 64'(b) << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; dout shows the head entry
// combinationally. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped console UART on the data-memory request bus: THR/RBR/LSR
// decode, one-cycle response register, paced TX drain and RX console polling.
//
// state  | meaning
// S_WAIT | no byte held; counting cycles until the next console poll
// S_POLL | io_uart_in_valid high; io_uart_in_ch sampled this cycle
// S_HOLD | received byte held (DR=1); polling paused until RBR is read
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [63:0] BASE     = UART_BASE,
  parameter int          TX_DEPTH = 8,
  parameter int          TX_GAP   = 0,
  parameter int          RX_POLL  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch
);

  localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
  localparam int PW = (RX_POLL > 1) ? $clog2(RX_POLL) : 1;

  logic [2:0]  lane;
  logic        in_win, thr_store, accept, rbr_read, lsr_read;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_idle, dr;
  logic [7:0]  tx_dout, lsr;
  logic [63:0] rdata_d;

  logic        resp_valid_q, resp_err_q;
  logic [63:0] resp_rdata_q;
  logic        out_valid_q;
  logic [7:0]  out_ch_q;
  logic [GW-1:0] gap_q;

  rx_state_e   rx_state_q, rx_state_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        in_valid_q;

  logic        unused_ok;
  assign unused_ok = ^{req_wdata[63:8], req_wstrb[7:1]};

  assign lane      = req_addr[2:0];
  assign in_win    = (req_addr[63:3] == BASE[63:3]);
  assign thr_store = req_valid & req_we & (req_addr == BASE) & req_wstrb[0];
  // The stall looks at the registered full flag, so a same-edge pop does not let a store in.
  assign req_ready = ~reset & ~(thr_store & tx_full);
  assign accept    = req_valid & req_ready;
  assign tx_push   = accept & thr_store;
  assign rbr_read  = accept & ~req_we & in_win & (lane == UART_THR);
  assign lsr_read  = accept & ~req_we & in_win & (lane == UART_LSR);
  assign dr        = (rx_state_q == S_HOLD);

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (req_wdata[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_pop  = ~tx_empty & (gap_q == '0);
  assign tx_idle = ~out_valid_q & (gap_q == '0);

  always_comb begin
    lsr           = '0;
    lsr[LSR_DR]   = dr;
    lsr[LSR_THRE] = ~tx_full;
    lsr[LSR_TEMT] = tx_empty & tx_idle;
  end

  always_comb begin
    rdata_d = '0;
    if (rbr_read && dr) rdata_d = lane_place(UART_THR, rx_byte_q);
    else if (lsr_read)  rdata_d = lane_place(UART_LSR, lsr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= accept;
      resp_err_q   <= accept & ~in_win;
      resp_rdata_q <= rdata_d;
    end
  end

  // Gap counter is a down-counter reloaded on every pop; the head may pop only at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      gap_q       <= '0;
    end else begin
      out_valid_q <= tx_pop;
      if (tx_pop) begin
        out_ch_q <= tx_dout;
        gap_q    <= GW'(TX_GAP);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - GW'(1);
      end
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    poll_cnt_d = poll_cnt_q;
    rx_byte_d  = rx_byte_q;
    case (rx_state_q)
      S_WAIT: begin
        if (poll_cnt_q == PW'(RX_POLL - 1)) begin
          rx_state_d = S_POLL;
          poll_cnt_d = '0;
        end else begin
          poll_cnt_d = poll_cnt_q + PW'(1);
        end
      end
      S_POLL: begin
        if (io_uart_in_ch != UART_NODATA) begin
          rx_byte_d  = io_uart_in_ch;
          rx_state_d = S_HOLD;
        end else begin
          rx_state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (rbr_read) rx_state_d = S_WAIT;
      end
      default: rx_state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= S_WAIT;
      poll_cnt_q <= '0;
      rx_byte_q  <= '0;
      in_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      poll_cnt_q <= poll_cnt_d;
      rx_byte_q  <= rx_byte_d;
      in_valid_q <= (rx_state_d == S_POLL);
    end
  end

  assign resp_valid        = resp_valid_q;
  assign resp_err          = resp_err_q;
  assign resp_rdata        = resp_rdata_q;
  assign io_uart_out_valid = out_valid_q;
  assign io_uart_out_ch    = out_ch_q;
  assign io_uart_in_valid  = in_valid_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: two instances (TX_GAP=0 and TX_GAP=3),
// expected responses and TX bytes queued at issue, checked by negedge monitors.
module tb_uart_mmio;
  import uart_mmio_pkg::*;

  localparam logic [63:0] LSR_ADDR = UART_BASE + 64'd5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  reset, req_valid, req_we, req_ready, resp_valid, resp_err;
  logic [1:0]  out_valid, in_valid;
  logic [63:0] req_addr [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_wstrb [2];
  logic [63:0] resp_rdata0, resp_rdata1;
  logic [7:0]  out_ch0, out_ch1;
  logic [7:0]  in_ch0;
  wire  [7:0]  in_ch1 = 8'hFF;

  uart_mmio #(.BASE(UART_BASE), .TX_DEPTH(8), .TX_GAP(0), .RX_POLL(16)) dut0 (
    .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata0), .resp_err(resp_err[0]),
    .io_uart_out_valid(out_valid[0]), .io_uart_out_ch(out_ch0),
    .io_uart_in_valid(in_valid[0]), .io_uart_in_ch(in_ch0));

  uart_mmio #(.BASE(UART_BASE), .TX_DEPTH(8), .TX_GAP(3), .RX_POLL(16)) dut1 (
    .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata1), .resp_err(resp_err[1]),
    .io_uart_out_valid(out_valid[1]), .io_uart_out_ch(out_ch1),
    .io_uart_in_valid(in_valid[1]), .io_uart_in_ch(in_ch1));

  typedef struct { logic err; logic [63:0] rdata; int cyc; } resp_t;
  typedef struct { logic [7:0] ch; int cyc; int gap; } tx_t;

  resp_t rq0[$], rq1[$];
  tx_t   tq0[$], tq1[$];
  logic [7:0] rx_replies[$];
  int n_checks = 0, n_fail = 0, cyc = 0;
  int last_pulse0 = 0, last_pulse1 = 0, pulses1 = 0;
  int polls = 0, poll_cyc1 = 0, poll_cyc2 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen/missing contrary to expectation at cycle %0d", name, cyc);
  endtask

  // Monitors: responses, transmitted bytes, console polls
  always @(negedge clock) begin
    resp_t r;
    tx_t   t;
    if (resp_valid[0]) begin
      if (rq0.size() == 0) fail("dut0 unexpected resp");
      else begin
        r = rq0.pop_front();
        check("dut0 resp cycle", 64'(cyc), 64'(r.cyc));
        check("dut0 resp err", 64'(resp_err[0]), 64'(r.err));
        check("dut0 resp rdata", resp_rdata0, r.rdata);
      end
    end
    if (resp_valid[1]) begin
      if (rq1.size() == 0) fail("dut1 unexpected resp");
      else begin
        r = rq1.pop_front();
        check("dut1 resp cycle", 64'(cyc), 64'(r.cyc));
        check("dut1 resp err", 64'(resp_err[1]), 64'(r.err));
        check("dut1 resp rdata", resp_rdata1, r.rdata);
      end
    end
    if (out_valid[0]) begin
      if (tq0.size() == 0) fail("dut0 unexpected tx byte");
      else begin
        t = tq0.pop_front();
        check("dut0 tx ch", 64'(out_ch0), 64'(t.ch));
        if (t.cyc >= 0) check("dut0 tx cycle", 64'(cyc), 64'(t.cyc));
        if (t.gap > 0)  check("dut0 tx spacing", 64'(cyc - last_pulse0), 64'(t.gap));
      end
      last_pulse0 = cyc;
    end
    if (out_valid[1]) begin
      pulses1++;
      if (tq1.size() == 0) fail("dut1 unexpected tx byte");
      else begin
        t = tq1.pop_front();
        check("dut1 tx ch", 64'(out_ch1), 64'(t.ch));
        if (t.cyc >= 0) check("dut1 tx cycle", 64'(cyc), 64'(t.cyc));
        if (t.gap > 0)  check("dut1 tx spacing", 64'(cyc - last_pulse1), 64'(t.gap));
      end
      last_pulse1 = cyc;
    end
    if (in_valid[0]) begin
      polls++;
      if (polls == 1) poll_cyc1 = cyc;
      if (polls == 2) poll_cyc2 = cyc;
      in_ch0 = (rx_replies.size() != 0) ? rx_replies.pop_front() : UART_NODATA;
    end
  end

  // tx_kind: 0 no byte expected, 1 byte at accept+2, 2 byte tx_gap cycles after the previous one
  task automatic access(input int k, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wstrb,
                        input logic exp_err, input logic [63:0] exp_rdata,
                        input int tx_kind, input int tx_gap, output int stalls);
    resp_t r;
    tx_t   t;
    bit    done = 0;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wstrb[k] = wstrb;
    stalls = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (req_ready[k]) begin
        r.err = exp_err; r.rdata = exp_rdata; r.cyc = cyc + 1;
        if (k == 0) rq0.push_back(r); else rq1.push_back(r);
        if (tx_kind != 0) begin
          t.ch  = wdata[7:0];
          t.cyc = (tx_kind == 1) ? cyc + 2 : -1;
          t.gap = (tx_kind == 2) ? tx_gap : 0;
          if (k == 0) tq0.push_back(t); else tq1.push_back(t);
        end
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clock); #1;
    end
    if (!done) fail("access accept timeout");
  endtask

  task automatic idle(input int k);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_polls(input int n);
    for (int i = 0; i < 60 && polls < n; i++) step(1);
    if (polls < n) fail("console poll timeout");
  endtask

  task automatic wait_drain(input int k);
    for (int i = 0; i < 200 && ((k == 0) ? tq0.size() : tq1.size()) != 0; i++) step(1);
    if (((k == 0) ? tq0.size() : tq1.size()) != 0) fail("tx drain timeout");
  endtask

  initial begin
    int st, p0;
    reset = 2'b11; req_valid = '0; req_we = '0; in_ch0 = UART_NODATA;
    for (int k = 0; k < 2; k++) begin
      req_addr[k] = '0; req_wdata[k] = '0; req_wstrb[k] = '0;
    end
    rx_replies.push_back(8'hFF);
    rx_replies.push_back(8'h7A);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst req_ready0", 64'(req_ready[0]), 64'd0);
    check("rst resp_valid0", 64'(resp_valid[0]), 64'd0);
    check("rst resp_rdata0", resp_rdata0, 64'd0);
    check("rst resp_err0", 64'(resp_err[0]), 64'd0);
    check("rst out_valid0", 64'(out_valid[0]), 64'd0);
    check("rst out_ch0", 64'(out_ch0), 64'd0);
    check("rst in_valid0", 64'(in_valid[0]), 64'd0);
    check("rst req_ready1", 64'(req_ready[1]), 64'd0);
    check("rst out_valid1", 64'(out_valid[1]), 64'd0);
    @(posedge clock); #1;
    reset = 2'b00;

    // RX: first poll returns no data, second returns 0x7A
    wait_polls(1);
    access(0, 0, LSR_ADDR, 0, 0, 0, 64'h0000_6000_0000_0000, 0, 0, st);
    idle(0);
    wait_polls(2);
    check("poll interval", 64'(poll_cyc2 - poll_cyc1), 64'd17);

    access(0, 0, UART_BASE + 64'h100, 0, 0, 1, 64'd0, 0, 0, st);
    access(0, 1, UART_BASE + 64'h100, 64'h55, 8'hFF, 1, 64'd0, 0, 0, st);
    access(0, 1, UART_BASE, 64'h66, 8'h02, 0, 64'd0, 0, 0, st);
    access(0, 1, UART_BASE + 64'd1, 64'h7700, 8'h02, 0, 64'd0, 0, 0, st);
    access(0, 0, UART_BASE + 64'd3, 0, 0, 0, 64'd0, 0, 0, st);
    access(0, 0, LSR_ADDR, 0, 0, 0, 64'h0000_6100_0000_0000, 0, 0, st);
    access(0, 1, UART_BASE, 64'h31, 8'h01, 0, 64'd0, 1, 0, st);
    access(0, 1, UART_BASE, 64'h32, 8'h01, 0, 64'd0, 2, 1, st);
    access(0, 1, UART_BASE, 64'h33, 8'h01, 0, 64'd0, 2, 1, st);
    access(0, 0, LSR_ADDR, 0, 0, 0, 64'h0000_2100_0000_0000, 0, 0, st);
    check("no poll while DR", 64'(polls), 64'd2);
    access(0, 0, UART_BASE, 0, 0, 0, 64'h7A, 0, 0, st);
    access(0, 0, LSR_ADDR, 0, 0, 0, 64'h0000_6000_0000_0000, 0, 0, st);
    access(0, 0, UART_BASE, 0, 0, 0, 64'd0, 0, 0, st);
    idle(0);
    step(6);

    // Single THR store: response next cycle, byte two cycles after accept
    access(0, 1, UART_BASE, 64'h41, 8'h01, 0, 64'd0, 1, 0, st);
    idle(0);
    step(6);

    // Ten back-to-back stores with TX_GAP=0: draining keeps pace, no stall
    for (int i = 0; i < 10; i++) begin
      access(0, 1, UART_BASE, 64'h50 + 64'(i), 8'h01, 0, 64'd0, (i == 0) ? 1 : 2, 1, st);
      check("gap0 burst stall", 64'(st), 64'd0);
    end
    idle(0);
    wait_drain(0);
    step(2);
    access(0, 0, LSR_ADDR, 0, 0, 0, 64'h0000_6000_0000_0000, 0, 0, st);
    idle(0);

    // TX_GAP=3: three bytes four cycles apart
    for (int i = 0; i < 3; i++)
      access(1, 1, UART_BASE, 64'hA1 + 64'(i), 8'h01, 0, 64'd0, (i == 0) ? 1 : 2, 4, st);
    idle(1);
    wait_drain(1);
    step(6);
    access(1, 0, LSR_ADDR, 0, 0, 0, 64'h0000_6000_0000_0000, 0, 0, st);
    idle(1);
    step(2);

    // TX_GAP=3, 14 back-to-back stores: FIFO fills after the 11th, later stores wait 3 cycles each
    for (int i = 0; i < 14; i++) begin
      access(1, 1, UART_BASE, 64'hC0 + 64'(i), 8'h01, 0, 64'd0, (i == 0) ? 1 : 2, 4, st);
      check("full fifo stall", 64'(st), (i < 11) ? 64'd0 : 64'd3);
    end
    idle(1);
    wait_drain(1);
    step(6);

    // Reset mid-drain: only the first of five bytes gets out
    for (int i = 0; i < 5; i++)
      access(1, 1, UART_BASE, 64'hD0 + 64'(i), 8'h01, 0, 64'd0, (i == 0) ? 1 : 2, 4, st);
    idle(1);
    reset[1] = 1'b1;
    check("dut1 D0 emitted before reset", 64'(tq1.size()), 64'd4);
    tq1.delete();
    p0 = pulses1;
    @(negedge clock);
    check("reset req_ready1", 64'(req_ready[1]), 64'd0);
    step(3);
    reset[1] = 1'b0;
    step(30);
    check("dut1 pulses after reset", 64'(pulses1 - p0), 64'd0);
    access(1, 0, LSR_ADDR, 0, 0, 0, 64'h0000_6000_0000_0000, 0, 0, st);
    idle(1);
    step(4);

    check("dut0 resp queue drained", 64'(rq0.size()), 64'd0);
    check("dut1 resp queue drained", 64'(rq1.size()), 64'd0);
    check("dut0 tx queue drained", 64'(tq0.size()), 64'd0);
    check("dut1 tx queue drained", 64'(tq1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
